reg_dump_reader: RTL

- Read-side counterpart of the register file's write port, for the debug path.
- On a start request, walks all architectural registers through a read-address port, captures each word, and emits it as a byte stream over a valid/ready handshake toward the debug UART transmitter.
- Sits between the register file's debug read port and the debug unit's TX FIFO/UART.

---
 rtl/reg_dump_reader_pkg.sv | 21 ++
 rtl/reg_dump_reader_word_serializer.sv | 74 +++++++
 rtl/reg_dump_reader.sv | 91 +++++++++
 3 files changed

// File: rtl/reg_dump_reader_pkg.sv
// rtl/reg_dump_reader_pkg.sv - shared debug package for the register dump path
// Holds FSM state encodings, default register-file geometry and the
// bytes-per-word helper used by the dump reader and its serializer.
package reg_dump_reader_pkg;

  localparam int DEF_N_REGS = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 32;

  localparam int BYTES_PER_WORD = DEF_DATA_W / 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_SEND = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  function automatic int bytes_per_word(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/reg_dump_reader_word_serializer.sv
// rtl/reg_dump_reader_word_serializer.sv - splits one captured word into a byte stream
// Ports:
//   clk, i_rst_n         clock, async active-low reset
//   i_load               capture i_word and start sending its bytes
//   i_word               word to serialize
//   o_tx_data/o_tx_valid byte stream toward the transmitter
//   i_tx_ready           transmitter accepts the byte this cycle
//   o_last_acc           last byte of the word accepted this cycle
module reg_dump_reader_word_serializer
  import reg_dump_reader_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MSB_FIRST = 1
) (
  input  logic              clk,
  input  logic              i_rst_n,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_word,
  output logic [7:0]        o_tx_data,
  output logic              o_tx_valid,
  input  logic              i_tx_ready,
  output logic              o_last_acc
);

  localparam int BPW   = bytes_per_word(DATA_W);
  localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;

  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              valid_q, valid_d;
  logic              hs;
  logic              last_byte;

  assign hs        = valid_q & i_tx_ready;
  assign last_byte = (cnt_q == CNT_W'(BPW - 1));

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    if (i_load) begin
      shift_d = i_word;
      cnt_d   = '0;
      valid_d = 1'b1;
    end else if (hs) begin
      if (last_byte) begin
        valid_d = 1'b0;
      end else begin
        cnt_d = cnt_q + 1'b1;
        // The byte on the wire is always at a fixed end of the shift
        // register, so shifting presents the next byte in order.
        shift_d = (MSB_FIRST != 0) ? (shift_q << 8) : (shift_q >> 8);
      end
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      shift_q <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  assign o_tx_valid = valid_q;
  assign o_tx_data  = !valid_q ? 8'h00 :
                      (MSB_FIRST != 0) ? shift_q[DATA_W-1 -: 8] : shift_q[7:0];
  assign o_last_acc = hs & last_byte;

endmodule

// File: rtl/reg_dump_reader.sv
// rtl/reg_dump_reader.sv - walks the register file debug port and streams every word as bytes
// Ports:
//   clk, i_rst_n          clock, async active-low reset
//   i_start               dump request, level-sampled in IDLE
//   o_rd_addr, i_rd_data  register file debug read port (combinational data)
//   o_tx_data/o_tx_valid  byte stream to the debug transmitter
//   i_tx_ready            transmitter accepts the byte this cycle
//   o_busy                dump in progress
//   o_done                one-cycle pulse after the final byte is accepted
module reg_dump_reader
  import reg_dump_reader_pkg::*;
#(
  parameter int N_REGS    = DEF_N_REGS,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MSB_FIRST = 1
) (
  input  logic              clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic [DATA_W-1:0] i_rd_data,
  output logic [7:0]        o_tx_data,
  output logic              o_tx_valid,
  input  logic              i_tx_ready,
  output logic              o_busy,
  output logic              o_done
);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              load;
  logic              last_acc;

  assign load = (state_q == ST_LOAD);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d = ST_LOAD;
          idx_d   = '0;
        end
      end
      ST_LOAD: state_d = ST_SEND;
      ST_SEND: begin
        if (last_acc) begin
          // Index saturates at the final register; it never wraps.
          if (idx_q < ADDR_W'(N_REGS - 1)) begin
            idx_d   = idx_q + 1'b1;
            state_d = ST_LOAD;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  reg_dump_reader_word_serializer #(
    .DATA_W   (DATA_W),
    .MSB_FIRST(MSB_FIRST)
  ) u_ser (
    .clk       (clk),
    .i_rst_n   (i_rst_n),
    .i_load    (load),
    .i_word    (i_rd_data),
    .o_tx_data (o_tx_data),
    .o_tx_valid(o_tx_valid),
    .i_tx_ready(i_tx_ready),
    .o_last_acc(last_acc)
  );

  assign o_rd_addr = idx_q;
  assign o_busy    = (state_q == ST_LOAD) || (state_q == ST_SEND);
  assign o_done    = (state_q == ST_DONE);

endmodule
